// File: rtl/mips_pkg.sv
// Shared writeback constants and requester identifiers for the register-file
// write arbiter.
package mips_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;

  // Identifies a writeback source; also used as the round-robin pointer value.
  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

  // Requester that should be favoured after `id` has been granted.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ALU) ? REQ_LOAD : REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Two writeback request channels (ALU and load) with valid/ready handshakes.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              r0_valid;
  logic [ADDR_W-1:0] r0_reg;
  logic [DATA_W-1:0] r0_data;
  logic              r0_ready;

  logic              r1_valid;
  logic [ADDR_W-1:0] r1_reg;
  logic [DATA_W-1:0] r1_data;
  logic              r1_ready;

  modport master (
    output r0_valid, r0_reg, r0_data,
    output r1_valid, r1_reg, r1_data,
    input  r0_ready, r1_ready
  );

  modport slave (
    input  r0_valid, r0_reg, r0_data,
    input  r1_valid, r1_reg, r1_data,
    output r0_ready, r1_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: purely combinational, the caller holds the pointer
// and loads ptr_nxt on each clock edge.
module rr_arbiter2
  import mips_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    ptr,
  output logic [1:0] grant,
  output req_id_e    ptr_nxt
);

  // Grant the lone requester, or the favoured one when both request
  always_comb begin
    grant   = 2'b00;
    ptr_nxt = ptr;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == REQ_LOAD) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (grant[1]) begin
      ptr_nxt = other_req(REQ_LOAD);
    end else if (grant[0]) begin
      ptr_nxt = other_req(REQ_ALU);
    end else begin
      ptr_nxt = ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port and
// tracks registers with reserved, still-unwritten results.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_arbiter_if.slave    wb,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_reg,
  output logic [2**ADDR_W-1:0]   busy_mask,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic                   grant_id
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [1:0]        req_s;
  logic [1:0]        grant_s;
  req_id_e           ptr_r;
  req_id_e           ptr_nxt_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] sel_reg_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [NREGS-1:0]  clr_s;
  logic [NREGS-1:0]  set_s;
  logic [NREGS-1:0]  busy_nxt_s;
  logic [NREGS-1:0]  busy_r;
  logic              regwrite_r;
  logic [ADDR_W-1:0] write_reg_r;
  logic [DATA_W-1:0] write_data_r;
  logic              grant_id_r;

  // Requests are masked during reset so no handshake can complete.
  assign req_s = reset ? 2'b00 : {wb.r1_valid, wb.r0_valid};

  rr_arbiter2 u_rr (
    .req     (req_s),
    .ptr     (ptr_r),
    .grant   (grant_s),
    .ptr_nxt (ptr_nxt_s)
  );

  assign wb.r0_ready = grant_s[0];
  assign wb.r1_ready = grant_s[1];
  assign xfer_s      = grant_s[0] | grant_s[1];
  assign sel_reg_s   = grant_s[1] ? wb.r1_reg  : wb.r0_reg;
  assign sel_data_s  = grant_s[1] ? wb.r1_data : wb.r0_data;

  // Set is applied after clear so a same-cycle reservation wins; bit 0 never sets.
  assign clr_s      = xfer_s ? ({{(NREGS-1){1'b0}}, 1'b1} << sel_reg_s) : {NREGS{1'b0}};
  assign set_s      = rsv_valid ? ({{(NREGS-1){1'b0}}, 1'b1} << rsv_reg) : {NREGS{1'b0}};
  assign busy_nxt_s = ((busy_r & ~clr_s) | set_s) & {{(NREGS-1){1'b1}}, 1'b0};

  // Reservation scoreboard
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Round-robin pointer advances only on an accepted transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= REQ_ALU;
    end else if (xfer_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Output stage: one-cycle write pulse, index/data held between transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_r   <= 1'b0;
      write_reg_r  <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      grant_id_r   <= 1'b0;
    end else if (xfer_s) begin
      regwrite_r   <= (sel_reg_s != {ADDR_W{1'b0}});
      write_reg_r  <= sel_reg_s;
      write_data_r <= sel_data_s;
      grant_id_r   <= grant_s[1];
    end else begin
      regwrite_r   <= 1'b0;
      write_reg_r  <= write_reg_r;
      write_data_r <= write_data_r;
      grant_id_r   <= grant_id_r;
    end
  end

  assign busy_mask  = busy_r;
  assign RegWrite   = regwrite_r;
  assign write_reg  = write_reg_r;
  assign write_data = write_data_r;
  assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a reference model feeding an
// expected-write queue that is checked one cycle after each stimulus cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic [31:0] busy_mask;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        grant_id;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) wb ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb         (wb.slave),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .busy_mask  (busy_mask),
    .RegWrite   (RegWrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rg;
    logic [31:0] dt;
    logic        gid;
    logic [31:0] busy;
  } exp_t;

  exp_t        exp_q[$];
  int          nchecks = 0;
  int          nerrors = 0;

  // Reference model state
  logic        m_ptr  = 1'b0;
  logic [31:0] m_busy = 32'h0;
  logic [4:0]  m_reg  = 5'd0;
  logic [31:0] m_data = 32'h0;
  logic        m_gid  = 1'b0;
  int          m_xfer = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: check ready, predict the write, then check outputs after the edge.
  task automatic cycle(input string tag);
    logic        er0, er1, xf, gid;
    logic [4:0]  rg;
    logic [31:0] dt, nb;
    exp_t        e;
    #2;
    er0 = 1'b0;
    er1 = 1'b0;
    if (!reset) begin
      if (wb.r0_valid && wb.r1_valid) begin
        if (m_ptr) er1 = 1'b1; else er0 = 1'b1;
      end else if (wb.r0_valid) begin
        er0 = 1'b1;
      end else if (wb.r1_valid) begin
        er1 = 1'b1;
      end
    end
    chk({tag, "/r0_ready"}, 64'(wb.r0_ready), 64'(er0));
    chk({tag, "/r1_ready"}, 64'(wb.r1_ready), 64'(er1));
    xf  = er0 | er1;
    gid = er1;
    rg  = gid ? wb.r1_reg  : wb.r0_reg;
    dt  = gid ? wb.r1_data : wb.r0_data;
    if (reset) begin
      m_ptr = 1'b0; m_busy = 32'h0; m_reg = 5'd0; m_data = 32'h0; m_gid = 1'b0;
      e = '{rw: 1'b0, rg: 5'd0, dt: 32'h0, gid: 1'b0, busy: 32'h0};
    end else begin
      nb = m_busy;
      if (xf) nb[rg] = 1'b0;
      if (rsv_valid) nb[rsv_reg] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      if (xf) begin
        m_reg = rg; m_data = dt; m_gid = gid; m_ptr = ~gid;
      end
      e = '{rw: xf && (rg != 5'd0), rg: m_reg, dt: m_data, gid: m_gid, busy: m_busy};
    end
    exp_q.push_back(e);
    m_xfer = xf ? (gid ? 2 : 1) : 0;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "/RegWrite"},   64'(RegWrite),   64'(e.rw));
    chk({tag, "/write_reg"},  64'(write_reg),  64'(e.rg));
    chk({tag, "/write_data"}, 64'(write_data), 64'(e.dt));
    chk({tag, "/grant_id"},   64'(grant_id),   64'(e.gid));
    chk({tag, "/busy_mask"},  64'(busy_mask),  64'(e.busy));
  endtask

  initial begin
    reset = 1'b1;
    rsv_valid = 1'b0; rsv_reg = 5'd0;
    wb.r0_valid = 1'b0; wb.r0_reg = 5'd0; wb.r0_data = 32'h0;
    wb.r1_valid = 1'b0; wb.r1_reg = 5'd0; wb.r1_data = 32'h0;
    cycle("reset0");
    wb.r0_valid = 1'b1; wb.r1_valid = 1'b1;
    cycle("reset_valid_held");
    wb.r0_valid = 1'b0; wb.r1_valid = 1'b0;
    reset = 1'b0;
    cycle("idle");

    // Single ALU write
    wb.r0_valid = 1'b1; wb.r0_reg = 5'd5; wb.r0_data = 32'hDEADBEEF;
    cycle("r0_only");
    wb.r0_valid = 1'b0;
    cycle("after_r0");

    // Load write to r0 is accepted but suppressed
    wb.r1_valid = 1'b1; wb.r1_reg = 5'd0; wb.r1_data = 32'h00001234;
    cycle("r1_reg0");
    wb.r1_valid = 1'b0;
    cycle("after_reg0");

    // Both requesting: alternate grants, fresh data after each grant
    wb.r0_valid = 1'b1; wb.r0_reg = 5'd3; wb.r0_data = 32'hA0000001;
    wb.r1_valid = 1'b1; wb.r1_reg = 5'd4; wb.r1_data = 32'hB0000001;
    for (int i = 0; i < 4; i++) begin
      cycle("rr");
      chk("rr_order", 64'(grant_id), 64'(i % 2));
      if (m_xfer == 1) wb.r0_data = wb.r0_data + 32'h1;
      else if (m_xfer == 2) wb.r1_data = wb.r1_data + 32'h1;
    end
    wb.r0_valid = 1'b0; wb.r1_valid = 1'b0;
    cycle("rr_drain");

    // Reserve r7, wait, then write it
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    cycle("rsv7");
    rsv_valid = 1'b0;
    cycle("rsv7_hold");
    chk("busy7_set", 64'(busy_mask[7]), 64'(1'b1));
    wb.r0_valid = 1'b1; wb.r0_reg = 5'd7; wb.r0_data = 32'h77777777;
    cycle("wr7");
    chk("busy7_clr", 64'(busy_mask[7]), 64'(1'b0));
    wb.r0_valid = 1'b0;

    // Reservation and write of r9 in the same cycle: reservation survives
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    wb.r1_valid = 1'b1; wb.r1_reg = 5'd9; wb.r1_data = 32'h99999999;
    cycle("rsv_wr9");
    chk("busy9_kept", 64'(busy_mask[9]), 64'(1'b1));
    rsv_valid = 1'b0; wb.r1_valid = 1'b0;

    // Reserving r0 sets nothing
    rsv_valid = 1'b1; rsv_reg = 5'd0;
    cycle("rsv0");
    rsv_valid = 1'b0;

    // Same destination from both requesters, serialized
    wb.r0_valid = 1'b1; wb.r0_reg = 5'd12; wb.r0_data = 32'hC0C0C0C0;
    wb.r1_valid = 1'b1; wb.r1_reg = 5'd12; wb.r1_data = 32'hD1D1D1D1;
    for (int i = 0; i < 2; i++) begin
      cycle("same_reg");
      if (m_xfer == 1) wb.r0_valid = 1'b0;
      else if (m_xfer == 2) wb.r1_valid = 1'b0;
    end
    wb.r0_valid = 1'b0; wb.r1_valid = 1'b0;

    // Write to r2 then reset on the following edge
    wb.r0_valid = 1'b1; wb.r0_reg = 5'd2; wb.r0_data = 32'h22222222;
    cycle("wr2");
    reset = 1'b1;
    cycle("reset_mid");
    cycle("reset_mid2");
    wb.r0_valid = 1'b0;
    reset = 1'b0;
    cycle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
